square_finder: RTL
==================

// Module: square_finder
// PURPOSE
//  Iterative squarer: computes alpha*alpha as the sum of the first alpha odd numbers (1+3+5+...).
//  Inverse of the lab square root finder. Used to generate test operands for it and to check its
//  results in a loop. Start/valid handshake; result is shown through the existing display block.
// PARAMETERS
//  WIDTH    4   operand width; result width is 2*WIDTH
// PORTS
//  clock    in   1          system clock; all state updates on posedge
//  clear    in   1          synchronous, active-high reset
//  start    in   1          request a computation; sampled only in IDLE
//  alpha    in   WIDTH      operand; captured on the edge that accepts start
//  square   out  2*WIDTH    result register; holds the last completed result
//  valid    out  1          one-cycle pulse: square has just been updated
//  busy     out  1          high in LOAD, ADD and DONE; start is ignored while high
// BEHAVIOUR
//  Reset (clear=1 at posedge): state=IDLE, square=0, valid=0, busy=0, all internal registers 0.
//  clear has priority over every other input, including start in the same cycle.
//  clear during LOAD/ADD/DONE: the computation is aborted, no valid pulse is issued, and square=0.
//  States: IDLE, LOAD, ADD, DONE.
//   IDLE: if start=1 -> alpha_reg<=alpha; go to LOAD. Otherwise stay in IDLE.
//   LOAD: acc<=0, delta<=1, count<=0. If alpha_reg==0 go to DONE, else go to ADD.
//   ADD : acc<=acc+delta, delta<=delta+2, count<=count+1 on every cycle.
//         When count==alpha_reg-1 (the last add), go to DONE.
//   DONE: square<=acc, valid=1 for this cycle only, then go to IDLE.
//  Latency: start accepted at edge k -> valid is high during cycle k+alpha+2.
//   alpha=0: 2 cycles. alpha=2^WIDTH-1: 2^WIDTH+1 cycles.
//  Widths:
//   acc: 2*WIDTH bits; never overflows, since max (2^WIDTH-1)^2 fits.
//   delta: WIDTH+1 bits; max value 2*alpha-1.
//   count: WIDTH bits.
//   Zero-extend all operands before adding; no truncation is permitted.
//  Input sampling:
//   alpha changes after acceptance have no effect on the running computation.
//   start held high: a new computation begins in the IDLE cycle after DONE (back-to-back).
//  Outputs:
//   square changes only in DONE (or on clear); it is never driven with partial sums.
//   valid and busy are registered outputs, decoded from the state register.
// STRUCTURE
//  Package square_finder_pkg:
//   state encoding (IDLE=2'b00, LOAD=2'b01, ADD=2'b10, DONE=2'b11);
//   default WIDTH.
//  Sub-module square_finder_data: datapath holding alpha_reg, acc, delta, count and square.
//   Controls in: load, add, store. Flag out: last (count==alpha_reg-1), zero (alpha_reg==0).
//  Top level: the control FSM plus one square_finder_data instance.
//  Display hookup: display digit_1/digit_2 = square[3:0]/square[7:4]; done outside this block.
// TESTING
//  1 Reset: hold clear 2 cycles -> square=0, valid=0, busy=0; state=IDLE.
//  2 alpha=0, pulse start -> valid in cycle k+2, square=0; busy high for exactly 2 cycles.
//  3 alpha=3 -> square=9 with valid at k+5. alpha=15 -> square=225 (8'hE1) with valid at k+17.
//  4 alpha=5 start; at k+2 set alpha=9 and pulse start -> ignored; result 25, single valid.
//  5 alpha=12 start; clear at k+6 -> no valid; square=0, IDLE; next start alpha=4 -> 16.
//  6 Sweep alpha 0..15 with start held high (back-to-back) -> square=alpha^2 each time;
//    self-check against a model; 16 valid pulses.

Source files
------------

// File: rtl/square_finder_pkg.sv
// rtl/square_finder_pkg.sv - shared state encoding and default operand width for the iterative squarer
package square_finder_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    ADD  = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/square_finder_data.sv
// rtl/square_finder_data.sv - operand, odd-number accumulator and result registers of the squarer
module square_finder_data
  import square_finder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 capture,
  input  logic                 load,
  input  logic                 add,
  input  logic                 store,
  input  logic [WIDTH-1:0]     alpha,
  output logic [2*WIDTH-1:0]   square,
  output logic                 last,
  output logic                 zero
);

  localparam int AW = 2 * WIDTH;
  localparam int DW = WIDTH + 1;

  logic [WIDTH-1:0] alpha_reg;
  logic [WIDTH-1:0] count;
  logic [DW-1:0]    delta;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_next;

  // square is stored from acc_next so the final sum is visible while valid is high
  always_comb begin
    acc_next = acc;
    if (load) begin
      acc_next = '0;
    end else if (add) begin
      acc_next = acc + AW'(delta);
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      alpha_reg <= '0;
      count     <= '0;
      delta     <= '0;
      acc       <= '0;
      square    <= '0;
    end else begin
      if (capture) begin
        alpha_reg <= alpha;
      end
      if (load) begin
        count <= '0;
        delta <= DW'(1);
      end else if (add) begin
        count <= count + WIDTH'(1);
        delta <= delta + DW'(2);
      end
      acc <= acc_next;
      if (store) begin
        square <= acc_next;
      end
    end
  end

  assign last = (count == alpha_reg - WIDTH'(1));
  assign zero = (alpha_reg == '0);

endmodule

// File: rtl/square_finder.sv
// rtl/square_finder.sv - iterative squarer: alpha*alpha as the sum of the first alpha odd numbers
module square_finder
  import square_finder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   alpha,
  output logic [2*WIDTH-1:0] square,
  output logic               valid,
  output logic               busy
);

  state_t state;
  state_t state_next;
  logic   capture;
  logic   load;
  logic   add;
  logic   store;
  logic   last;
  logic   zero;

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // store fires on the edge entering DONE, so square is fresh during the valid cycle
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    load       = 1'b0;
    add        = 1'b0;
    store      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        load = 1'b1;
        if (zero) begin
          store      = 1'b1;
          state_next = DONE;
        end else begin
          state_next = ADD;
        end
      end
      ADD: begin
        add = 1'b1;
        if (last) begin
          store      = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign valid = (state == DONE);
  assign busy  = (state != IDLE);

  square_finder_data #(
    .WIDTH(WIDTH)
  ) u_data (
    .clock   (clock),
    .clear   (clear),
    .capture (capture),
    .load    (load),
    .add     (add),
    .store   (store),
    .alpha   (alpha),
    .square  (square),
    .last    (last),
    .zero    (zero)
  );

endmodule
